// File: rtl/mem_access_ctrl.sv
// Single-outstanding memory access controller: latches a CPU request, drives the
// memory handshake with a bounded wait, and reports completion with a one-cycle done pulse.
module mem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Counter reaching this value without an ack ends the access as a timeout.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic       weLatched;
    logic [7:0] waitCount;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            weLatched <= 1'b0;
            waitCount <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (req) begin
                        mem_addr  <= addr;
                        mem_wdata <= wdata;
                        weLatched <= we;
                        busy      <= 1'b1;
                        // Misaligned requests are rejected without touching memory.
                        if (addr[1:0] != 2'b00) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= ACCESS;
                            waitCount <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= we;
                        end
                    end
                end

                ACCESS: begin
                    if (mem_ack) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        err     <= 1'b0;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (!weLatched) begin
                            rdata <= mem_rdata;
                        end
                    end else if (waitCount == TIMEOUT_LAST) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end else begin
                        waitCount <= waitCount + 8'd1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    err     <= 1'b0;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a transaction-level model is compared every cycle,
// and hand-computed literals pin each scenario.
module tb_mem_access_ctrl;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              req       = 1'b0;
    logic              we        = 1'b0;
    logic [ADDR_W-1:0] addr      = '0;
    logic [DATA_W-1:0] wdata     = '0;
    logic              mem_ack   = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              busy, done, err, mem_req, mem_we;
    logic [DATA_W-1:0] rdata, mem_wdata;
    logic [ADDR_W-1:0] mem_addr;

    int nCmp  = 0;
    int nFail = 0;
    bit chkEn = 1'b0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 = waiting for a request, 1 = memory transaction open, 2 = reporting.
    int          mPhase  = 0;
    int          mWaited = 0;
    bit          mDone   = 1'b0;
    bit          mErr    = 1'b0;
    bit          mWe     = 1'b0;
    logic [31:0] mAddr   = '0;
    logic [31:0] mWdata  = '0;
    logic [31:0] mRdata  = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mPhase = 0; mWaited = 0; mDone = 1'b0; mErr = 1'b0; mWe = 1'b0;
            mAddr = '0; mWdata = '0; mRdata = '0;
        end else begin
            mDone = 1'b0;
            if (mPhase == 2) begin
                mPhase = 0;
            end else if (mPhase == 1) begin
                if (mem_ack === 1'b1) begin
                    mPhase = 2; mDone = 1'b1; mErr = 1'b0;
                    if (!mWe) mRdata = mem_rdata;
                end else if (mWaited + 1 == TIMEOUT) begin
                    mPhase = 2; mDone = 1'b1; mErr = 1'b1;
                end else begin
                    mWaited++;
                end
            end else if (req === 1'b1) begin
                mAddr = addr; mWdata = wdata; mWe = we;
                if ((addr % 4) != 0) begin
                    mPhase = 2; mDone = 1'b1; mErr = 1'b1;
                end else begin
                    mPhase = 1; mWaited = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chkEn) begin
            chk1("m_busy", busy, mPhase != 0);
            chk1("m_done", done, mDone);
            if (mDone) chk1("m_err", err, mErr);
            chk1("m_mem_req", mem_req, mPhase == 1);
            chk1("m_mem_we", mem_we, (mPhase == 1) && mWe);
            chk32("m_mem_addr", mem_addr, mAddr);
            chk32("m_mem_wdata", mem_wdata, mWdata);
            chk32("m_rdata", rdata, mRdata);
        end
    end

    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d);
        req = 1'b1; addr = a; we = w; wdata = d;
    endtask

    int cnt;
    bit seenDone;

    initial begin
        #1 rst = 1'b0;
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk32("rst_rdata", rdata, 32'h0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chkEn = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Misaligned read
        @(negedge clk); issue(32'h0000000F, 1'b0, 32'hAAAA5555);
        @(negedge clk); req = 1'b0;
        chk1("mis_done", done, 1'b1);
        chk1("mis_err", err, 1'b1);
        chk1("mis_mem_req", mem_req, 1'b0);
        @(negedge clk);
        chk1("mis_done_fall", done, 1'b0);
        chk1("mis_busy_fall", busy, 1'b0);

        // Aligned read, ack in the first ACCESS cycle
        issue(32'h00000010, 1'b0, 32'h0);
        @(negedge clk); req = 1'b0;
        chk1("rd_mem_req", mem_req, 1'b1);
        chk32("rd_mem_addr", mem_addr, 32'h00000010);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk); mem_ack = 1'b0; mem_rdata = 32'h0;
        chk1("rd_done", done, 1'b1);
        chk1("rd_err", err, 1'b0);
        chk32("rd_rdata", rdata, 32'hDEADBEEF);
        @(negedge clk);
        chk1("rd_done_fall", done, 1'b0);

        // Ack while idle must be ignored
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        repeat (2) @(negedge clk);
        chk1("idle_ack_busy", busy, 1'b0);
        chk32("idle_ack_rdata", rdata, 32'hDEADBEEF);
        mem_ack = 1'b0;

        // Write with ack in the third ACCESS cycle
        issue(32'h00000020, 1'b1, 32'h12345678);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); req = 1'b0;
            chk1("wr_mem_we", mem_we, 1'b1);
            chk32("wr_mem_wdata", mem_wdata, 32'h12345678);
            if (i == 2) begin
                mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
            end
        end
        @(negedge clk); mem_ack = 1'b0;
        chk1("wr_done", done, 1'b1);
        chk1("wr_err", err, 1'b0);
        chk1("wr_mem_we_off", mem_we, 1'b0);
        chk32("wr_rdata_kept", rdata, 32'hDEADBEEF);
        @(negedge clk);

        // Timeout with ack never arriving
        issue(32'h00000040, 1'b0, 32'h0);
        cnt = 0; seenDone = 1'b0;
        for (int i = 0; i < 40 && !seenDone; i++) begin
            @(negedge clk); req = 1'b0;
            if (done) seenDone = 1'b1;
            else if (mem_req) cnt++;
        end
        chk1("to_done_seen", seenDone, 1'b1);
        chk32("to_req_cycles", 32'(cnt), 32'd16);
        chk1("to_err", err, 1'b1);
        chk32("to_rdata_kept", rdata, 32'hDEADBEEF);
        @(negedge clk);

        // Ack on the final allowed cycle wins over timeout
        issue(32'h00000044, 1'b0, 32'h0);
        mem_rdata = 32'hCAFEF00D;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); req = 1'b0;
            chk1("late_mem_req", mem_req, 1'b1);
            if (i == 15) mem_ack = 1'b1;
        end
        @(negedge clk); mem_ack = 1'b0;
        chk1("late_done", done, 1'b1);
        chk1("late_err", err, 1'b0);
        chk32("late_rdata", rdata, 32'hCAFEF00D);
        @(negedge clk);

        // Back-to-back reads with req held high
        issue(32'h00000050, 1'b0, 32'h0);
        @(negedge clk);
        chk1("b2b_req1", mem_req, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        @(negedge clk); mem_ack = 1'b0;
        chk1("b2b_done1", done, 1'b1);
        chk32("b2b_rdata1", rdata, 32'h11111111);
        @(negedge clk);
        chk1("b2b_gap_busy", busy, 1'b0);
        chk1("b2b_gap_req", mem_req, 1'b0);
        @(negedge clk);
        chk1("b2b_req2", mem_req, 1'b1);
        chk1("b2b_busy2", busy, 1'b1);
        req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h22222222;
        @(negedge clk); mem_ack = 1'b0;
        chk1("b2b_done2", done, 1'b1);
        chk32("b2b_rdata2", rdata, 32'h22222222);
        repeat (2) @(negedge clk);
        chk1("b2b_idle", busy, 1'b0);

        // Reset two cycles into ACCESS
        issue(32'h00000060, 1'b0, 32'h0);
        @(negedge clk); req = 1'b0;
        @(negedge clk);
        chk1("mid_mem_req", mem_req, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk1("mid_rst_mem_req", mem_req, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_done", done, 1'b0);
        chk32("mid_rst_rdata", rdata, 32'h0);
        chk32("mid_rst_mem_addr", mem_addr, 32'h0);
        repeat (2) @(negedge clk);
        chk1("mid_rst_no_done", done, 1'b0);

        // First request after reset release is honoured at once
        rst = 1'b1;
        issue(32'h00000070, 1'b0, 32'h0);
        @(negedge clk); req = 1'b0;
        chk1("post_rst_req", mem_req, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'h77777777;
        @(negedge clk); mem_ack = 1'b0;
        chk1("post_rst_done", done, 1'b1);
        chk32("post_rst_rdata", rdata, 32'h77777777);
        @(negedge clk);

        chkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, 32, address width; matches the memory address register output.
REQ-002 Parameter DATA_W, 32, data word width.
REQ-003 Parameter TIMEOUT, 16, maximum ACCESS-state cycles to wait for mem_ack; legal range 2..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 req  input  1  CPU-side access request; sampled only in IDLE.
REQ-007 we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 addr  input  ADDR_W  access address, driven from the memory address register output.
REQ-009 wdata  input  DATA_W  write data; sampled with req.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  error qualifier; meaningful only while done=1.
REQ-013 rdata  output  DATA_W  last successfully read word.
REQ-014 mem_req  output  1  memory-side request.
REQ-015 mem_we  output  1  memory-side write enable.
REQ-016 mem_addr  output  ADDR_W  memory-side address.
REQ-017 mem_wdata  output  DATA_W  memory-side write data.
REQ-018 mem_ack  input  1  memory-side acknowledge.
REQ-019 mem_rdata  input  DATA_W  memory read data; valid in the cycle mem_ack=1.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, ACCESS, DONE.
REQ-021 In IDLE with req=1 at a rising edge, the block SHALL latch addr, we and wdata into internal registers.
REQ-022 At that same edge, if addr[1:0]!=0 (misaligned), the block SHALL go to DONE with err=1 and never assert mem_req.
REQ-023 At that same edge, if addr[1:0]==0 (aligned), the block SHALL go to ACCESS and clear the timeout counter.
REQ-024 In ACCESS, mem_req SHALL be 1, and mem_addr/mem_we/mem_wdata SHALL be driven from the latched registers and held stable.
REQ-025 Outside ACCESS, mem_req and mem_we SHALL be 0; mem_addr/mem_wdata SHALL hold their latched values.
REQ-026 In ACCESS with mem_ack=1 at an edge, the FSM SHALL go to DONE with err=0.
REQ-027 On an ack-terminated read, rdata SHALL capture mem_rdata at that same edge.
REQ-028 In ACCESS, the timeout counter SHALL increment each cycle without mem_ack.
REQ-029 When the counter equals TIMEOUT-1 with mem_ack=0, the FSM SHALL go to DONE with err=1 and leave rdata unchanged.
REQ-030 If mem_ack=1 at the timeout edge, ack SHALL win: err=0 and read data is captured.
REQ-031 In DONE, done=1 for exactly one cycle, with err valid alongside it, and the FSM SHALL then return to IDLE unconditionally.
REQ-032 Minimum latency: req sampled at edge k and mem_ack=1 at edge k+1 SHALL give done=1 during the cycle after edge k+1.
REQ-033 req SHALL be ignored in ACCESS and DONE; a request held high SHALL be re-sampled on the first edge after returning to IDLE.
REQ-034 mem_ack SHALL be ignored in IDLE and DONE.
REQ-035 rdata SHALL change only on a successful read; writes and errors SHALL leave it unchanged.

Reset
REQ-036 While rst=0, asynchronously and without waiting for clk: state SHALL be IDLE; busy, done, err, mem_req, mem_we SHALL be 0; rdata, mem_addr, mem_wdata and the timeout counter SHALL be 0.
REQ-037 Reset asserted mid-ACCESS SHALL drop mem_req immediately, and no done pulse SHALL follow.
REQ-038 The first req SHALL be honoured on the first rising edge after rst returns to 1.

Verification
REQ-039 Read: addr=0x0000000F -> done=1, err=1, mem_req never asserted (misaligned); repeat with addr=0x00000010, mem_ack one cycle later, mem_rdata=0xDEADBEEF -> done one cycle, err=0, rdata=0xDEADBEEF.
REQ-040 Write: addr=0x00000020, wdata=0x12345678, we=1, mem_ack after 3 cycles -> mem_we=1, mem_wdata=0x12345678 for all 3 ACCESS cycles, then done with err=0 and rdata unchanged.
REQ-041 Timeout: TIMEOUT=16, mem_ack held 0 -> mem_req high exactly 16 cycles, then done=1 and err=1; mem_ack=1 on cycle 16 instead -> err=0.
REQ-042 Back-to-back: req held high across two reads -> the second mem_req rises the edge after done falls, and busy drops for exactly one cycle between accesses.
REQ-043 Reset: rst=0 asserted two cycles into ACCESS -> mem_req=0 and busy=0 immediately, no done pulse, and rdata=0.
